// File: rtl/hazard_tracker_pkg.sv
// ---------------------------------------------------------------------------
// hazard_tracker_pkg
// Shared constants and types for the producer side of the stall/forward
// protocol.
//   T_PC / T_ALU / T_DM : Tnew codes an instruction carries into E
//   FWD_RF .. FWD_W     : forwarding source select encodings
//   stage_t             : one pipeline-stage record {tnew, a3, we}
//   satDec()            : saturating decrement used as Tnew ages
// ---------------------------------------------------------------------------
package hazard_tracker_pkg;

    localparam logic [1:0] T_PC  = 2'd0;
    localparam logic [1:0] T_ALU = 2'd1;
    localparam logic [1:0] T_DM  = 2'd2;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    typedef struct packed {
        logic [1:0] tnew;
        logic [4:0] a3;
        logic       we;
    } stage_t;

    localparam stage_t BUBBLE = '0;

    // Tnew counts down toward "result ready" and must never wrap past zero.
    function automatic logic [1:0] satDec(input logic [1:0] x);
        return (x != 2'd0) ? (x - 2'd1) : 2'd0;
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// ---------------------------------------------------------------------------
// hazard_stage_reg
// One {Tnew, a3, we} pipeline-stage register for the hazard tracker.
//   clk       : clock
//   reset     : synchronous active-high reset, clears to a bubble
//   bubble_i  : load a bubble instead of entry_i on this edge
//   entry_i   : record arriving from the previous stage
//   entry_o   : registered record for this stage
// Parameters:
//   DEC_TNEW  : age Tnew by one (saturating) while moving into this stage
//   KEEP_TNEW : when 0 the stored Tnew is forced to zero (result stage)
// ---------------------------------------------------------------------------
module hazard_stage_reg
    import hazard_tracker_pkg::*;
#(
    parameter bit DEC_TNEW  = 1'b0,
    parameter bit KEEP_TNEW = 1'b1
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   bubble_i,
    input  stage_t entry_i,
    output stage_t entry_o
);

    stage_t entry_q;
    stage_t entry_d;

    // Build the next record: optionally age Tnew, never track writes to $0
    // (so a zero a3 can never produce a forwarding match), and let a bubble
    // request override everything.
    always_comb begin
        entry_d = entry_i;
        if (DEC_TNEW) begin
            entry_d.tnew = satDec(entry_i.tnew);
        end
        if (!KEEP_TNEW) begin
            entry_d.tnew = 2'd0;
        end
        entry_d.we = entry_i.we & (entry_i.a3 != 5'd0);
        if (bubble_i) begin
            entry_d = BUBBLE;
        end
    end

    // Stage storage; reset empties the stage just like a bubble would.
    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q <= BUBBLE;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/hazard_tracker.sv
// ---------------------------------------------------------------------------
// hazard_tracker
// Producer side of the stall/forward protocol. Tracks destination register,
// write-valid and Tnew for the instructions in E, M and W, produces the
// D-stage forwarding selects and a mult/div busy countdown.
//   clk, reset            : clock, synchronous active-high reset
//   tnew_d, a3_d, we_d    : D-stage instruction entering E
//   stall                 : D held, bubble goes into E
//   flush                 : cancel E, M and W (wins over stall)
//   md_start_e, md_div_e  : E-stage starts mult (div when md_div_e)
//   rs_d, rt_d            : D-stage source registers to forward
//   Tnew_e, Tnew_m        : per-stage remaining time to result
//   a3_e, a3_m, a3_w      : per-stage destination registers
//   W_E, W_M, W_W         : per-stage write valid
//   fwd_rs, fwd_rt        : source selects (0 RF, 1 E, 2 M, 3 W)
//   md_busy               : mult/div unit busy
// ---------------------------------------------------------------------------
module hazard_tracker
    import hazard_tracker_pkg::*;
#(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] tnew_d,
    input  logic [4:0] a3_d,
    input  logic       we_d,
    input  logic       stall,
    input  logic       flush,
    input  logic       md_start_e,
    input  logic       md_div_e,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    output logic [1:0] Tnew_e,
    output logic [1:0] Tnew_m,
    output logic [4:0] a3_e,
    output logic [4:0] a3_m,
    output logic [4:0] a3_w,
    output logic       W_E,
    output logic       W_M,
    output logic       W_W,
    output logic [1:0] fwd_rs,
    output logic [1:0] fwd_rt,
    output logic       md_busy
);

    localparam int unsigned MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC);

    stage_t eIn;
    stage_t eStage;
    stage_t mStage;
    stage_t wStage;
    logic   eBubble;

    logic [CNT_W-1:0] mdCnt_q;
    logic [CNT_W-1:0] mdCnt_d;
    logic             mdStartValid;

    // A stalled D slot sends a bubble into E; a flush empties all stages.
    assign eIn     = '{tnew: tnew_d, a3: a3_d, we: we_d};
    assign eBubble = stall | flush;

    hazard_stage_reg #(.DEC_TNEW(1'b0), .KEEP_TNEW(1'b1)) uStageE (
        .clk      (clk),
        .reset    (reset),
        .bubble_i (eBubble),
        .entry_i  (eIn),
        .entry_o  (eStage)
    );

    hazard_stage_reg #(.DEC_TNEW(1'b1), .KEEP_TNEW(1'b1)) uStageM (
        .clk      (clk),
        .reset    (reset),
        .bubble_i (flush),
        .entry_i  (eStage),
        .entry_o  (mStage)
    );

    hazard_stage_reg #(.DEC_TNEW(1'b0), .KEEP_TNEW(1'b0)) uStageW (
        .clk      (clk),
        .reset    (reset),
        .bubble_i (flush),
        .entry_i  (mStage),
        .entry_o  (wStage)
    );

    assign Tnew_e = eStage.tnew;
    assign Tnew_m = mStage.tnew;
    assign a3_e   = eStage.a3;
    assign a3_m   = mStage.a3;
    assign a3_w   = wStage.a3;
    assign W_E    = eStage.we;
    assign W_M    = mStage.we;
    assign W_W    = wStage.we;

    // A stage can supply a source only when it will write that register and
    // its result already exists (Tnew of zero; W always holds zero).
    function automatic logic stageHit(input stage_t st, input logic [4:0] src);
        return (src != 5'd0) && st.we && (st.a3 == src) && (st.tnew == 2'd0);
    endfunction

    // Youngest ready stage wins so the most recent write to a register is
    // the one that reaches D. A not-yet-ready young match falls through to
    // older stages; D is being held by the stall detector in that case.
    always_comb begin
        fwd_rs = FWD_RF;
        if (stageHit(eStage, rs_d)) begin
            fwd_rs = FWD_E;
        end else if (stageHit(mStage, rs_d)) begin
            fwd_rs = FWD_M;
        end else if (stageHit(wStage, rs_d)) begin
            fwd_rs = FWD_W;
        end

        fwd_rt = FWD_RF;
        if (stageHit(eStage, rt_d)) begin
            fwd_rt = FWD_E;
        end else if (stageHit(mStage, rt_d)) begin
            fwd_rt = FWD_M;
        end else if (stageHit(wStage, rt_d)) begin
            fwd_rt = FWD_W;
        end
    end

    // Mult/div countdown. A (non-flushed) start always reloads, even over a
    // running operation; a flush never aborts work already started.
    assign mdStartValid = md_start_e & ~flush;

    always_comb begin
        mdCnt_d = mdCnt_q;
        if (mdStartValid) begin
            mdCnt_d = md_div_e ? DIV_LOAD : MULT_LOAD;
        end else if (mdCnt_q != '0) begin
            mdCnt_d = mdCnt_q - CNT_W'(1);
        end
    end

    // Counter storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            mdCnt_q <= '0;
        end else begin
            mdCnt_q <= mdCnt_d;
        end
    end

    // Busy also covers the start cycle itself, before the counter loads.
    assign md_busy = (mdCnt_q != '0) | mdStartValid;

endmodule

// File: tb/tb_hazard_tracker.sv
// ---------------------------------------------------------------------------
// tb_hazard_tracker
// Self-checking bench for hazard_tracker: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model holding the three in-flight instructions by age.
// ---------------------------------------------------------------------------
module tb_hazard_tracker;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] tnew_d;
    logic [4:0] a3_d;
    logic       we_d;
    logic       stall;
    logic       flush;
    logic       md_start_e;
    logic       md_div_e;
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic [1:0] Tnew_e;
    logic [1:0] Tnew_m;
    logic [4:0] a3_e;
    logic [4:0] a3_m;
    logic [4:0] a3_w;
    logic       W_E;
    logic       W_M;
    logic       W_W;
    logic [1:0] fwd_rs;
    logic [1:0] fwd_rt;
    logic       md_busy;

    int compared   = 0;
    int mismatched = 0;

    // Model state: slot 0 is the instruction in E, 1 in M, 2 in W. Each keeps
    // the Tnew it had on entering E; its current Tnew follows from its age.
    typedef struct {
        int tnew0;
        int a3;
        bit we;
    } ent_t;

    ent_t pipe[3];
    int   cycle   = 0;
    int   busyEnd = -1;

    always #5 clk = ~clk;

    hazard_tracker #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk        (clk),
        .reset      (reset),
        .tnew_d     (tnew_d),
        .a3_d       (a3_d),
        .we_d       (we_d),
        .stall      (stall),
        .flush      (flush),
        .md_start_e (md_start_e),
        .md_div_e   (md_div_e),
        .rs_d       (rs_d),
        .rt_d       (rt_d),
        .Tnew_e     (Tnew_e),
        .Tnew_m     (Tnew_m),
        .a3_e       (a3_e),
        .a3_m       (a3_m),
        .a3_w       (a3_w),
        .W_E        (W_E),
        .W_M        (W_M),
        .W_W        (W_W),
        .fwd_rs     (fwd_rs),
        .fwd_rt     (fwd_rt),
        .md_busy    (md_busy)
    );

    function automatic int tnewAt(int s);
        int t;
        if (s == 2) return 0;
        t = pipe[s].tnew0 - s;
        return (t > 0) ? t : 0;
    endfunction

    function automatic int expFwd(int src);
        if (src == 0) return 0;
        for (int s = 0; s < 3; s++) begin
            if (pipe[s].we && pipe[s].a3 == src && tnewAt(s) == 0) return s + 1;
        end
        return 0;
    endfunction

    function automatic bit expBusy();
        return (cycle <= busyEnd) || (md_start_e && !flush);
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycle, act, exp);
        end
    endtask

    task automatic checkOutput();
        checkValue("Tnew_e",  32'(Tnew_e),  32'(tnewAt(0)));
        checkValue("Tnew_m",  32'(Tnew_m),  32'(tnewAt(1)));
        checkValue("a3_e",    32'(a3_e),    32'(pipe[0].a3));
        checkValue("a3_m",    32'(a3_m),    32'(pipe[1].a3));
        checkValue("a3_w",    32'(a3_w),    32'(pipe[2].a3));
        checkValue("W_E",     32'(W_E),     32'(pipe[0].we));
        checkValue("W_M",     32'(W_M),     32'(pipe[1].we));
        checkValue("W_W",     32'(W_W),     32'(pipe[2].we));
        checkValue("fwd_rs",  32'(fwd_rs),  32'(expFwd(int'(rs_d))));
        checkValue("fwd_rt",  32'(fwd_rt),  32'(expFwd(int'(rt_d))));
        checkValue("md_busy", 32'(md_busy), 32'(expBusy()));
    endtask

    task automatic clearModel();
        for (int s = 0; s < 3; s++) pipe[s] = '{tnew0: 0, a3: 0, we: 1'b0};
    endtask

    task automatic updateModel();
        ent_t incoming;
        if (reset) begin
            busyEnd = -1;
        end else if (md_start_e && !flush) begin
            busyEnd = cycle + (md_div_e ? DIV_CYC : MULT_CYC);
        end
        if (reset || flush) begin
            clearModel();
        end else begin
            incoming = '{tnew0: 0, a3: 0, we: 1'b0};
            if (!stall) incoming = '{tnew0: int'(tnew_d), a3: int'(a3_d), we: we_d && (a3_d != 5'd0)};
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = incoming;
        end
        cycle++;
    endtask

    task automatic clockEdge();
        @(posedge clk);
        updateModel();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [1:0] tn, input logic [4:0] a3, input logic we,
                                 input logic st, input logic fl, input logic ms, input logic md,
                                 input logic [4:0] rs, input logic [4:0] rt);
        tnew_d     = tn;
        a3_d       = a3;
        we_d       = we;
        stall      = st;
        flush      = fl;
        md_start_e = ms;
        md_div_e   = md;
        rs_d       = rs;
        rt_d       = rt;
        #1;
        checkOutput();
    endtask

    initial begin
        reset = 1'b1;
        tnew_d = 0; a3_d = 0; we_d = 0; stall = 0; flush = 0;
        md_start_e = 0; md_div_e = 0; rs_d = 0; rt_d = 0;
        clearModel();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkValue("rst_Tnew_e", 32'(Tnew_e), 0);
        checkValue("rst_W_W", 32'(W_W), 0);
        checkValue("rst_a3_w", 32'(a3_w), 0);
        checkValue("rst_md_busy", 32'(md_busy), 0);
        clockEdge();

        // Load then use
        applyStimulus(2, 8, 1, 0, 0, 0, 0, 0, 0);
        clockEdge();
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        checkValue("ldUse_Tnew_e", 32'(Tnew_e), 2);
        checkValue("ldUse_a3_e", 32'(a3_e), 8);
        checkValue("ldUse_W_E", 32'(W_E), 1);
        clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkValue("ldUse_stall_W_E", 32'(W_E), 0);
        checkValue("ldUse_Tnew_m", 32'(Tnew_m), 1);
        checkValue("ldUse_a3_m", 32'(a3_m), 8);
        checkValue("ldUse_W_M", 32'(W_M), 1);
        clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 8, 0);
        checkValue("ldUse_a3_w", 32'(a3_w), 8);
        checkValue("ldUse_W_W", 32'(W_W), 1);
        checkValue("ldUse_fwd_rs", 32'(fwd_rs), 3);
        clockEdge();

        // ALU forwarding from M
        applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0);
        clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5);
        checkValue("alu_Tnew_m", 32'(Tnew_m), 0);
        checkValue("alu_a3_m", 32'(a3_m), 5);
        checkValue("alu_fwd_rt", 32'(fwd_rt), 2);
        checkValue("alu_fwd_rs0", 32'(fwd_rs), 0);
        clockEdge();

        // Youngest stage wins
        repeat (3) begin
            applyStimulus(0, 9, 1, 0, 0, 0, 0, 0, 0);
            clockEdge();
        end
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 9, 0);
        checkValue("young_fwd_E", 32'(fwd_rs), 1);
        clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 9, 0);
        checkValue("young_W_E", 32'(W_E), 0);
        checkValue("young_fwd_M", 32'(fwd_rs), 2);
        clockEdge();

        // $0 is never tracked
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0);
        clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkValue("zero_W_E", 32'(W_E), 0);
        checkValue("zero_fwd_rs", 32'(fwd_rs), 0);
        clockEdge();

        // Flush over stall empties a full pipeline
        applyStimulus(1, 3, 1, 0, 0, 0, 0, 0, 0); clockEdge();
        applyStimulus(1, 4, 1, 0, 0, 0, 0, 0, 0); clockEdge();
        applyStimulus(1, 6, 1, 0, 0, 0, 0, 0, 0); clockEdge();
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 0, 0);
        checkValue("flush_full", 32'({W_E, W_M, W_W}), 7);
        clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkValue("flush_W", 32'({W_E, W_M, W_W}), 0);
        checkValue("flush_a3", 32'({a3_e, a3_m, a3_w}), 0);
        clockEdge();

        // Divide: busy on start cycle and the 10 after it
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 0);
        checkValue("div_busy_start", 32'(md_busy), 1);
        clockEdge();
        for (int i = 1; i <= DIV_CYC; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
            checkValue($sformatf("div_busy_%0d", i), 32'(md_busy), 1);
            clockEdge();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkValue("div_idle", 32'(md_busy), 0);
        clockEdge();

        // Restart with mult at cycle 3 of a divide
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 0); clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0); clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0); clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
        checkValue("restart_busy", 32'(md_busy), 1);
        clockEdge();
        for (int i = 1; i <= MULT_CYC; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
            checkValue($sformatf("mult_busy_%0d", i), 32'(md_busy), 1);
            clockEdge();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkValue("mult_idle", 32'(md_busy), 0);
        clockEdge();

        // Start under flush is dropped
        applyStimulus(0, 0, 0, 0, 1, 1, 1, 0, 0);
        checkValue("flushStart_busy", 32'(md_busy), 0);
        clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkValue("flushStart_after", 32'(md_busy), 0);
        clockEdge();

        // Mid-run reset clears stages and the counter
        applyStimulus(1, 7, 1, 0, 0, 0, 0, 0, 0); clockEdge();
        applyStimulus(1, 7, 1, 0, 0, 0, 0, 0, 0); clockEdge();
        applyStimulus(1, 7, 1, 0, 0, 1, 1, 0, 0); clockEdge();
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        clockEdge();
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 7, 7);
        checkValue("midRst_W", 32'({W_E, W_M, W_W}), 0);
        checkValue("midRst_a3", 32'({a3_e, a3_m, a3_w}), 0);
        checkValue("midRst_md_busy", 32'(md_busy), 0);
        checkValue("midRst_fwd_rs", 32'(fwd_rs), 0);
        clockEdge();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 79) == 0);
            applyStimulus(2'($urandom_range(0, 2)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            clockEdge();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hazard_tracker.md
Name: hazard_tracker

Overview:
- Producer side of the pipeline's stall/forward protocol.
- Carries each in-flight instruction's destination register, write-enable and remaining-time-to-result (Tnew) down the E, M and W stages.
- Decrements Tnew as the instruction advances, and publishes the per-stage values that the stall detector consumes.
- Also supplies forwarding selects for the D-stage source registers, and a multiply/divide busy countdown.

Parameters:
- MULT_CYC, 5, busy cycles after a mult/multu start.
- DIV_CYC, 10, busy cycles after a div/divu start.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- tnew_d  in  2  Tnew the D-stage instruction will have on entering E (T_PC=0, T_ALU=1, T_DM=2)
- a3_d  in  5  D-stage destination register
- we_d  in  1  D-stage writes a GPR
- stall  in  1  D held; bubble into E
- flush  in  1  exception/eret request; cancel E, M, W entries
- md_start_e  in  1  E-stage instruction starts the mult/div unit
- md_div_e  in  1  with md_start_e: operation is a divide
- rs_d  in  5  D-stage rs, forwarding query
- rt_d  in  5  D-stage rt, forwarding query
- Tnew_e  out  2  E-stage Tnew
- Tnew_m  out  2  M-stage Tnew
- a3_e  out  5  E-stage destination register
- a3_m  out  5  M-stage destination register
- a3_w  out  5  W-stage destination register
- W_E  out  1  E-stage write valid
- W_M  out  1  M-stage write valid
- W_W  out  1  W-stage write valid
- fwd_rs  out  2  rs source select: 0 regfile, 1 from E, 2 from M, 3 from W
- fwd_rt  out  2  same encoding, for rt
- md_busy  out  1  mult/div unit busy (counter nonzero or start this cycle)

Behaviour:
- Reset:
  - All stage registers are zero: Tnew_e=Tnew_m=0, a3_e=a3_m=a3_w=0, W_E=W_M=W_W=0.
  - md counter is 0.
  - Consequently fwd_rs=fwd_rt=0 and md_busy=0.
- Entry rule: an entry's write-valid is forced to 0 whenever its a3 is 0, since $0 is never tracked.
- Normal advance (stall=0, flush=0), per rising edge:
  - E <= {tnew_d, a3_d, we_d & (a3_d!=0)}.
  - M <= {sat_dec(Tnew_e), a3_e, W_E}.
  - W <= {a3_m, W_M}. W's Tnew is implicitly 0.
- sat_dec(x) = x-1 if x>0, else 0. Tnew never wraps: 0 stays 0.
- Stall (stall=1, flush=0):
  - E <= bubble {0,0,0}.
  - M and W advance from E and M as in the normal case.
  - D inputs are ignored that cycle; they are re-presented next cycle.
- Flush (flush=1): E, M and W are all cleared to bubbles on the edge, regardless of stall. flush has priority over stall.
- Forwarding selects (combinational; 1-cycle latency from D inputs to registered outputs):
  - fwd_rs = 1 if rs_d!=0 & W_E & a3_e==rs_d & Tnew_e==0.
  - Else 2 if rs_d!=0 & W_M & a3_m==rs_d & Tnew_m==0.
  - Else 3 if rs_d!=0 & W_W & a3_w==rs_d.
  - Else 0.
  - Youngest matching stage wins. fwd_rt is identical using rt_d.
  - A match whose Tnew is nonzero does not forward. The stall detector guarantees D is held in that case, so fwd may fall through to an older stage; that value is don't-care.
- md counter:
  - When md_start_e=1 and flush=0, the counter loads MULT_CYC or DIV_CYC (per md_div_e).
  - Otherwise it decrements while nonzero and holds at 0.
  - flush does not clear a running counter; an operation already started completes.
  - A start arriving while the counter is nonzero reloads the counter.
  - md_busy = (counter!=0) | (md_start_e & !flush).
- Counter width: clog2 of the larger of MULT_CYC and DIV_CYC, plus 1.
- No handshake with downstream consumers; all outputs are valid every cycle after reset.

Decomposition:
- Shared constants go in the existing global header: T_PC, T_ALU, T_DM, FWD_RF, FWD_E, FWD_M, FWD_W.
- One sub-module: hazard_stage_reg, a single {Tnew, a3, we} register with clear/bubble input and saturating-decrement option. Instantiated three times (E, M, W).
- Forward-select and md counter stay inline.

Test Plan:
- Load then use: tnew_d=2, a3_d=8, we_d=1, one edge → Tnew_e=2, a3_e=8, W_E=1. Next edge with stall=1 → Tnew_e=0, W_E=0; Tnew_m=1, a3_m=8, W_M=1. Next edge → a3_w=8, W_W=1. With rs_d=8 at that point → fwd_rs=3.
- ALU forwarding: tnew_d=1, a3_d=5, then two edges → Tnew_m=0, a3_m=5. With rt_d=5 → fwd_rt=2. With rs_d=0 → fwd_rs=0.
- Youngest wins: E{0,9,1}, M{0,9,1}, W{9,1}, rs_d=9 → fwd_rs=1. Clearing W_E → fwd_rs=2.
- $0 suppression: a3_d=0, we_d=1 → W_E=0 after edge. With rs_d=0 → fwd_rs=0.
- Flush: pipeline full (W_E=W_M=W_W=1), flush=1 with stall=1 → all W_* = 0 and all a3_* = 0 after the edge. Reset mid-run gives the same result plus md counter=0.
- Mult/div: md_start_e=1, md_div_e=1 → md_busy=1 that cycle and for 10 following cycles, 0 on the 11th. A restart with mult at cycle 3 → busy for 5 more cycles. A start with flush=1 → md_busy stays 0.
